norm_lut_arbiter: RTL
=====================

// Module: norm_lut_arbiter
// PURPOSE
//  Shares one synchronous-read lookup ROM (normalisation LUT: 1-cycle read, registered
//  data_out, enable-gated) between NUM_REQ requesting lanes. Arbitrates round-robin,
//  drives the ROM address/enable and routes each returned word to the lane that asked.
//  Sits between the normalisation lanes and the single LUT instance. One lookup per cycle.
// PARAMETERS
//  NUM_REQ     4    number of requesting lanes (>=2)
//  ADDR_WIDTH  6    ROM address width
//  DATA_WIDTH  16   ROM word width
//  CNT_WIDTH   32   width of the granted-lookup counter
// PORTS
//  clk           in   1                   clock, all logic on rising edge
//  reset         in   1                   asynchronous, active-low reset (0 = in reset)
//  req_valid     in   NUM_REQ             lane i requests a lookup
//  req_addr      in   NUM_REQ*ADDR_WIDTH  lane i address in bits [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_ready     out  NUM_REQ             one-hot grant; lane i's request accepted this cycle
//  rsp_valid     out  NUM_REQ             one-hot; rsp_data belongs to lane i this cycle
//  rsp_data      out  DATA_WIDTH          looked-up word
//  rom_address   out  ADDR_WIDTH          to ROM address
//  rom_enable    out  1                   to ROM enable
//  rom_data_out  in   DATA_WIDTH          from ROM data_out
//  busy          out  1                   lookup in flight or being issued
//  lookup_count  out  CNT_WIDTH           total granted lookups since reset
// BEHAVIOUR
//  - Reset (reset=0, async): rr_ptr=0, pipeline valids=0, rsp_valid=0, rsp_data=0,
//    lookup_count=0. req_ready/rom_enable are combinational, so 0 with no request.
//  - Arbitration (combinational): grant the first lane with req_valid=1 scanning
//    rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ. req_ready = one-hot grant; all 0 if no
//    valid. req_ready never asserts without the matching req_valid.
//  - Handshake: transfer when req_valid[i] & req_ready[i]. No skid; an unaccepted lane
//    holds valid and addr stable. No response backpressure: lanes must take rsp_valid.
//  - ROM drive: rom_enable = |req_valid; rom_address = granted lane's addr (0 if none).
//  - On a grant at edge T: rr_ptr <= (granted idx + 1) mod NUM_REQ; s1_valid<=1,
//    s1_id<=granted idx; lookup_count += 1 (wraps to 0 at 2^CNT_WIDTH). No grant:
//    rr_ptr holds, s1_valid<=0.
//  - ROM word is on rom_data_out in cycle T+1. At edge T+1: rsp_valid <= s1_valid ?
//    onehot(s1_id) : 0; rsp_data <= rom_data_out when s1_valid, else holds.
//  - Latency: request accepted in cycle T -> rsp_valid/rsp_data visible in cycle T+2.
//    Throughput 1 lookup/cycle, back-to-back, any lane mix; responses in grant order.
//  - busy = (|req_valid) | s1_valid | (|rsp_valid).
//  - Reset mid-operation: in-flight lookups are dropped, no rsp_valid after reset
//    release until a new grant + 2 cycles. The ROM's own reset is driven elsewhere.
//  - Same lane re-requesting every cycle while others wait: rr_ptr moves past it, so
//    every waiting lane is granted within NUM_REQ cycles (starvation-free).
// TESTING
//  1 Lane 2 only, addr=5, ROM[5]=16'h1234 -> req_ready=4'b0100 at T, rsp_valid=4'b0100,
//    rsp_data=16'h1234 at T+2; lookup_count=1.
//  2 All 4 lanes valid continuously from reset -> grants 0,1,2,3,0,... one per cycle;
//    responses same order, each with its own ROM word, no gaps.
//  3 Lanes 1,3 valid, rr_ptr=2 -> lane 3 granted first, then lane 1 (wrap), rr_ptr=2.
//  4 Lane 0 four back-to-back addrs 0,1,2,3 -> four consecutive rsp_valid=4'b0001
//    cycles with ROM[0..3] in order.
//  5 reset=0 asserted one cycle after a grant -> rsp_valid stays 0, lookup_count=0,
//    rr_ptr=0 after release; next request returns normally at +2.
//  6 CNT_WIDTH=3, nine grants -> lookup_count reads 1 (wrap); busy falls 0 two cycles
//    after last grant.

Source files
------------

// File: rtl/norm_lut_arbiter.sv
// Round-robin arbiter sharing one synchronous-read normalisation LUT between NUM_REQ lanes.
// Grants one lookup per cycle, drives the ROM port and routes each returned word to its lane.
module norm_lut_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ADDR_WIDTH-1:0]         rom_address,
    output logic                          rom_enable,
    input  logic [DATA_WIDTH-1:0]         rom_data_out,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          lookup_count
);

    localparam int              IDX_W     = $clog2(NUM_REQ);
    localparam logic [IDX_W:0]  NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]      rr_ptr_r;
    logic [IDX_W-1:0]      s1_id_r;
    logic                  s1_valid_r;
    logic [NUM_REQ-1:0]    rsp_valid_r;
    logic [DATA_WIDTH-1:0] rsp_data_r;
    logic [CNT_WIDTH-1:0]  lookup_count_r;

    logic                  grant_any_s;
    logic [IDX_W-1:0]      grant_idx_s;
    logic [IDX_W:0]        scan_sum_s;
    logic [IDX_W-1:0]      scan_idx_s;
    logic [NUM_REQ-1:0]    grant_s;
    logic [ADDR_WIDTH-1:0] rom_address_s;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            vec[i] = (idx == IDX_W'(i));
        end
        return vec;
    endfunction

    // Round-robin scan: first valid lane starting at rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        scan_sum_s  = '0;
        scan_idx_s  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum_s = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
            if (scan_sum_s >= NUM_REQ_W) begin
                scan_idx_s = IDX_W'(scan_sum_s - NUM_REQ_W);
            end else begin
                scan_idx_s = scan_sum_s[IDX_W-1:0];
            end
            if (!grant_any_s && req_valid[scan_idx_s]) begin
                grant_any_s = 1'b1;
                grant_idx_s = scan_idx_s;
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    // Grant decode and ROM address mux (address is zero when nothing is granted).
    always_comb begin
        grant_s       = '0;
        rom_address_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_s[i] = grant_any_s && (grant_idx_s == IDX_W'(i));
            if (grant_s[i]) begin
                rom_address_s = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end else begin
                rom_address_s = rom_address_s;
            end
        end
    end

    // Issue stage: pointer advance, in-flight tag and lookup counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_r       <= '0;
            s1_valid_r     <= 1'b0;
            s1_id_r        <= '0;
            lookup_count_r <= '0;
        end else if (grant_any_s) begin
            rr_ptr_r       <= (grant_idx_s == LAST_IDX) ? '0 : grant_idx_s + IDX_W'(1);
            s1_valid_r     <= 1'b1;
            s1_id_r        <= grant_idx_s;
            lookup_count_r <= lookup_count_r + CNT_WIDTH'(1);
        end else begin
            s1_valid_r     <= 1'b0;
        end
    end

    // Response stage: the ROM word for the in-flight lookup is captured and tagged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_r <= '0;
            rsp_data_r  <= '0;
        end else if (s1_valid_r) begin
            rsp_valid_r <= onehot(s1_id_r);
            rsp_data_r  <= rom_data_out;
        end else begin
            rsp_valid_r <= '0;
        end
    end

    assign req_ready    = grant_s;
    assign rom_enable   = |req_valid;
    assign rom_address  = rom_address_s;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_data     = rsp_data_r;
    assign lookup_count = lookup_count_r;
    assign busy         = (|req_valid) | s1_valid_r | (|rsp_valid_r);

endmodule
